// File: rtl/pwm_capture.sv
// pwm_capture: measures high time, period and per-mille duty of an asynchronous PWM
// input, with a sticky timeout for a stalled or stuck input.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_pwm,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [9:0]       o_duty,
  output logic             o_valid,
  output logic             o_timeout,
  output logic             o_overrun,
  output logic             o_level
);

  localparam int               NUM_W     = CNT_W + 10;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NUM_W-1:0] SCALE     = NUM_W'(1000);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DIV   = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  state_t           state_r;
  logic [CNT_W-1:0] per_cnt_r;
  logic [CNT_W-1:0] hi_cnt_r;
  logic [CNT_W-1:0] hi_sh_r;
  logic [CNT_W-1:0] per_sh_r;
  logic [NUM_W-1:0] rem_r;
  logic [CNT_W-1:0] div_r;
  logic [9:0]       quo_r;
  logic [3:0]       step_r;

  logic             rise_s;
  logic             timeout_hit_s;
  logic [CNT_W-1:0] per_adv_s;
  logic [CNT_W-1:0] hi_adv_s;
  logic [NUM_W-1:0] num_s;
  logic [3:0]       shift_s;
  logic [NUM_W-1:0] div_shift_s;
  logic             div_ge_s;
  logic [NUM_W-1:0] rem_next_s;
  logic [9:0]       quo_next_s;

  assign rise_s        = sync2_r & ~prev_r;
  // A rise in the same cycle as the timeout wins and restarts the counters.
  assign timeout_hit_s = (per_cnt_r >= TIMEOUT_C) & ~rise_s;
  assign per_adv_s     = rise_s ? CNT_ONE : sat_inc(per_cnt_r);
  assign hi_adv_s      = rise_s ? CNT_ONE : (sync2_r ? sat_inc(hi_cnt_r) : hi_cnt_r);
  assign num_s         = NUM_W'(hi_cnt_r) * SCALE;

  // Restoring division, one quotient bit per cycle, MSB first; quotient < 1024 since H < P.
  assign shift_s       = 4'd9 - step_r;
  assign div_shift_s   = NUM_W'(div_r) << shift_s;
  assign div_ge_s      = (rem_r >= div_shift_s);
  assign rem_next_s    = div_ge_s ? (rem_r - div_shift_s) : rem_r;
  assign quo_next_s    = {quo_r[8:0], div_ge_s};

  assign o_level       = sync2_r;

  // Two-flop synchronizer followed by the edge-detect flop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= i_pwm;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Capture state machine, counters, divider and registered results.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r      <= IDLE;
      per_cnt_r    <= CNT_ZERO;
      hi_cnt_r     <= CNT_ZERO;
      hi_sh_r      <= CNT_ZERO;
      per_sh_r     <= CNT_ZERO;
      rem_r        <= {NUM_W{1'b0}};
      div_r        <= CNT_ZERO;
      quo_r        <= 10'd0;
      step_r       <= 4'd0;
      o_high_cnt   <= CNT_ZERO;
      o_period_cnt <= CNT_ZERO;
      o_duty       <= 10'd0;
      o_valid      <= 1'b0;
      o_timeout    <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
      if (!i_enable) begin
        state_r   <= IDLE;
        per_cnt_r <= CNT_ZERO;
        hi_cnt_r  <= CNT_ZERO;
        hi_sh_r   <= CNT_ZERO;
        per_sh_r  <= CNT_ZERO;
        rem_r     <= {NUM_W{1'b0}};
        div_r     <= CNT_ZERO;
        quo_r     <= 10'd0;
        step_r    <= 4'd0;
        o_timeout <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              state_r   <= ARMED;
              per_cnt_r <= CNT_ONE;
              hi_cnt_r  <= CNT_ONE;
            end else begin
              per_cnt_r <= CNT_ZERO;
              hi_cnt_r  <= CNT_ZERO;
            end
          end
          ARMED: begin
            if (timeout_hit_s) begin
              state_r   <= IDLE;
              per_cnt_r <= CNT_ZERO;
              hi_cnt_r  <= CNT_ZERO;
              step_r    <= 4'd0;
              o_timeout <= 1'b1;
              o_duty    <= sync2_r ? 10'd999 : 10'd0;
              o_valid   <= 1'b1;
            end else begin
              per_cnt_r <= per_adv_s;
              hi_cnt_r  <= hi_adv_s;
              if (rise_s) begin
                hi_sh_r  <= hi_cnt_r;
                per_sh_r <= per_cnt_r;
                rem_r    <= num_s;
                div_r    <= per_cnt_r;
                quo_r    <= 10'd0;
                step_r   <= 4'd0;
                state_r  <= DIV;
              end else begin
                state_r  <= ARMED;
              end
            end
          end
          DIV: begin
            if (timeout_hit_s) begin
              state_r   <= IDLE;
              per_cnt_r <= CNT_ZERO;
              hi_cnt_r  <= CNT_ZERO;
              step_r    <= 4'd0;
              o_timeout <= 1'b1;
              o_duty    <= sync2_r ? 10'd999 : 10'd0;
              o_valid   <= 1'b1;
            end else begin
              per_cnt_r <= per_adv_s;
              hi_cnt_r  <= hi_adv_s;
              o_overrun <= rise_s;
              if (step_r == 4'd10) begin
                state_r <= ARMED;
              end else begin
                rem_r  <= rem_next_s;
                quo_r  <= quo_next_s;
                step_r <= step_r + 4'd1;
                if (step_r == 4'd9) begin
                  o_high_cnt   <= hi_sh_r;
                  o_period_cnt <= per_sh_r;
                  o_duty       <= quo_next_s;
                  o_valid      <= 1'b1;
                  o_timeout    <= 1'b0;
                end else begin
                  o_valid      <= 1'b0;
                end
              end
            end
          end
          default: begin
            state_r   <= IDLE;
            per_cnt_r <= CNT_ZERO;
            hi_cnt_r  <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: drives PWM frames and compares every result
// pulse against a frame-level reference model built from rise/fall timestamps.
module tb_pwm_capture;

  localparam int CNT_W = 16;
  localparam int TO    = 4000;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_enable;
  logic             i_pwm;
  logic [CNT_W-1:0] o_high_cnt;
  logic [CNT_W-1:0] o_period_cnt;
  logic [9:0]       o_duty;
  logic             o_valid;
  logic             o_timeout;
  logic             o_overrun;
  logic             o_level;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable), .i_pwm(i_pwm),
    .o_high_cnt(o_high_cnt), .o_period_cnt(o_period_cnt), .o_duty(o_duty),
    .o_valid(o_valid), .o_timeout(o_timeout), .o_overrun(o_overrun), .o_level(o_level)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    int hi;
    int per;
    int duty;
    bit to;
  } res_t;

  res_t exp_q[$];
  res_t m_r;

  // Reference model state, in bench input cycles.
  int t        = 0;
  bit cur_lvl  = 1'b0;
  bit m_en     = 1'b0;
  bit armed    = 1'b0;
  int t_rise   = 0;
  int t_fall   = 0;
  int t_cap    = 0;
  int exp_ovr  = 0;
  int obs_ovr  = 0;
  int last_hi  = 0;
  int last_per = 0;
  int seen333  = 0;

  task automatic drive_cycle(input bit lvl);
    res_t r;
    bit   rise;
    rise = lvl && !cur_lvl;
    if (m_en) begin
      if (rise) begin
        if (!armed) begin
          armed = 1'b1;
          t_cap = t - 100;
        end else if (t - t_cap >= 12) begin
          r.hi   = t_fall - t_rise;
          r.per  = t - t_rise;
          r.duty = (r.hi * 1000) / r.per;
          r.to   = 1'b0;
          exp_q.push_back(r);
          last_hi  = r.hi;
          last_per = r.per;
          t_cap    = t;
        end else begin
          exp_ovr++;
        end
        t_rise = t;
      end else begin
        if (!lvl && cur_lvl) t_fall = t;
        if (armed && (t - t_rise) == TO) begin
          r.hi   = last_hi;
          r.per  = last_per;
          r.duty = lvl ? 999 : 0;
          r.to   = 1'b1;
          exp_q.push_back(r);
          armed = 1'b0;
        end
      end
    end
    cur_lvl = lvl;
    i_pwm   = lvl;
    @(posedge i_clk);
    #1;
    t++;
  endtask

  task automatic pulse(input int p, input int h);
    repeat (h) drive_cycle(1'b1);
    repeat (p - h) drive_cycle(1'b0);
  endtask

  task automatic hold(input bit lvl, input int n);
    repeat (n) drive_cycle(lvl);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_high"},    o_high_cnt,   0);
    check({pfx, "_period"},  o_period_cnt, 0);
    check({pfx, "_duty"},    o_duty,       0);
    check({pfx, "_valid"},   o_valid,      0);
    check({pfx, "_timeout"}, o_timeout,    0);
    check({pfx, "_overrun"}, o_overrun,    0);
    check({pfx, "_level"},   o_level,      0);
  endtask

  // Result monitor: every o_valid must match the next modelled result.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_overrun) obs_ovr++;
      if (o_valid) begin
        check("valid_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          m_r = exp_q.pop_front();
          check("high",    o_high_cnt,   m_r.hi);
          check("period",  o_period_cnt, m_r.per);
          check("duty",    o_duty,       m_r.duty);
          check("timeout", o_timeout,    m_r.to);
          if (o_duty == 10'd333) seen333++;
        end
      end
    end
  end

  initial begin
    int p;
    int h;
    i_reset_n = 1'b0;
    i_enable  = 1'b0;
    i_pwm     = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_zero("reset");
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    i_enable  = 1'b1;
    m_en      = 1'b1;
    hold(1'b0, 10);

    // Nominal frames, then duty extremes and a short frame for the floor check.
    repeat (4) pulse(1000, 250);
    pulse(1000, 1);
    pulse(1000, 999);
    pulse(10, 5);
    pulse(3, 1);
    pulse(1000, 500);
    pulse(1000, 500);
    check("floor_333_seen", seen333, 1);

    // Fast frames: every second rise lands during the division.
    repeat (10) pulse(8, 4);
    repeat (2) pulse(1000, 500);
    check("overrun_cnt_fast", obs_ovr, exp_ovr);

    // Stuck high after a valid frame, then recovery.
    hold(1'b1, TO + 30);
    check("stuck_timeout", o_timeout, 1);
    check("stuck_duty", o_duty, 999);
    check("stuck_level", o_level, 1);
    hold(1'b0, 10);
    repeat (3) pulse(1000, 500);
    check("recover_timeout", o_timeout, 0);
    check("recover_duty", o_duty, 500);

    // Enable dropped mid-frame: results hold, no pulses while disabled.
    repeat (3) pulse(1000, 300);
    hold(1'b1, 300);
    hold(1'b0, 200);
    i_enable = 1'b0;
    m_en     = 1'b0;
    armed    = 1'b0;
    hold(1'b0, 20);
    repeat (2) pulse(100, 50);
    hold(1'b0, 20);
    check("dis_timeout", o_timeout, 0);
    check("dis_high", o_high_cnt, last_hi);
    check("dis_period", o_period_cnt, last_per);
    check("dis_duty", o_duty, 300);
    i_enable = 1'b1;
    m_en     = 1'b1;
    hold(1'b0, 10);
    repeat (3) pulse(1000, 700);
    check("reen_duty", o_duty, 700);

    // Reset asserted while a division is in flight.
    pulse(1000, 400);
    hold(1'b1, 5);
    i_reset_n = 1'b0;
    i_pwm     = 1'b0;
    cur_lvl   = 1'b0;
    #1;
    check_zero("rst_mid");
    exp_q.delete();
    armed    = 1'b0;
    last_hi  = 0;
    last_per = 0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    hold(1'b0, 10);
    repeat (3) pulse(1000, 400);
    check("post_rst_duty", o_duty, 400);

    // Randomized frames, including short periods that overrun.
    repeat (40) begin
      if ($urandom_range(3) == 0) p = $urandom_range(14, 2);
      else p = $urandom_range(1500, 15);
      h = $urandom_range(p - 1, 1);
      pulse(p, h);
    end

    // Stuck low ends in a timeout, which a disable then clears.
    hold(1'b0, TO + 30);
    check("stuck_low_timeout", o_timeout, 1);
    check("stuck_low_duty", o_duty, 0);
    i_enable = 1'b0;
    m_en     = 1'b0;
    hold(1'b0, 5);
    check("dis_clears_timeout", o_timeout, 0);
    check("overrun_cnt_total", obs_ovr, exp_ovr);
    check("results_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
